// File: rtl/byte_mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for single-byte reads and writes
// into a 24-bit-word data RAM with a registered read port.
module byte_mem_arbiter #(
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic [1:0]      we,
    input  logic [2*AW-1:0] addr,
    input  logic [3:0]      lane,
    input  logic [15:0]     wdata,
    output logic [1:0]      gnt,
    output logic [1:0]      done,
    output logic            err,
    output logic [7:0]      rdata,
    output logic            mem_en,
    output logic            mem_wren,
    output logic [AW-1:0]   mem_addr,
    output logic [2:0]      mem_byteena,
    output logic [23:0]     mem_wdata,
    input  logic [23:0]     mem_rdata,
    output logic [2:0]      state_dbg
);

    // Handshake: a requester holds req[i] and its fields stable until gnt[i]
    // pulses; gnt means the fields are latched, done[i] closes the transaction.
    // A req still high after done is a fresh request, sampled only in IDLE.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t state, state_next;

    logic ptr;
    logic cur_port;
    logic cur_we;
    logic [1:0] cur_lane;
    logic cur_bad;

    logic sel_port;
    logic sel_we;
    logic [AW-1:0] sel_addr;
    logic [1:0] sel_lane;
    logic [7:0] sel_wdata;
    logic take;

    logic [1:0]    gnt_d;
    logic [1:0]    done_d;
    logic          err_d;
    logic [7:0]    rdata_d;
    logic          mem_en_d;
    logic          mem_wren_d;
    logic [AW-1:0] mem_addr_d;
    logic [2:0]    mem_byteena_d;
    logic [23:0]   mem_wdata_d;

    // Sole requester wins; on contention the pointed port wins.
    assign sel_port  = (req == 2'b11) ? ptr : req[1];
    assign sel_we    = sel_port ? we[1] : we[0];
    assign sel_addr  = sel_port ? addr[2*AW-1:AW] : addr[AW-1:0];
    assign sel_lane  = sel_port ? lane[3:2] : lane[1:0];
    assign sel_wdata = sel_port ? wdata[15:8] : wdata[7:0];
    assign take      = (state == S_IDLE) && (req != 2'b00);
    assign cur_bad   = (cur_lane == 2'd3);
    assign state_dbg = state;

    always_comb begin
        state_next    = state;
        gnt_d         = 2'b00;
        done_d        = 2'b00;
        err_d         = 1'b0;
        rdata_d       = 8'h00;
        mem_en_d      = 1'b0;
        mem_wren_d    = 1'b0;
        mem_addr_d    = mem_addr;
        mem_byteena_d = 3'b000;
        mem_wdata_d   = mem_wdata;

        case (state)
            S_IDLE: begin
                if (take) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = (cur_we || cur_bad) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Outputs are computed one cycle ahead so every port is a flop.
        if (take) begin
            gnt_d = sel_port ? 2'b10 : 2'b01;
            if (sel_lane != 2'd3) begin
                mem_en_d   = 1'b1;
                mem_wren_d = sel_we;
                mem_addr_d = sel_addr;
                case (sel_lane)
                    2'd0: begin
                        mem_byteena_d = 3'b001;
                        mem_wdata_d   = {16'h0000, sel_wdata};
                    end
                    2'd1: begin
                        mem_byteena_d = 3'b010;
                        mem_wdata_d   = {8'h00, sel_wdata, 8'h00};
                    end
                    default: begin
                        mem_byteena_d = 3'b100;
                        mem_wdata_d   = {sel_wdata, 16'h0000};
                    end
                endcase
            end
        end

        if ((state == S_ISSUE && (cur_we || cur_bad)) || state == S_CAPTURE) begin
            done_d = cur_port ? 2'b10 : 2'b01;
            err_d  = (state == S_ISSUE) && cur_bad;
        end

        if (state == S_CAPTURE) begin
            case (cur_lane)
                2'd0:    rdata_d = mem_rdata[7:0];
                2'd1:    rdata_d = mem_rdata[15:8];
                default: rdata_d = mem_rdata[23:16];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= 1'b0;
            cur_port    <= 1'b0;
            cur_we      <= 1'b0;
            cur_lane    <= 2'd0;
            gnt         <= 2'b00;
            done        <= 2'b00;
            err         <= 1'b0;
            rdata       <= 8'h00;
            mem_en      <= 1'b0;
            mem_wren    <= 1'b0;
            mem_addr    <= '0;
            mem_byteena <= 3'b000;
            mem_wdata   <= 24'h000000;
        end else begin
            state       <= state_next;
            gnt         <= gnt_d;
            done        <= done_d;
            err         <= err_d;
            rdata       <= rdata_d;
            mem_en      <= mem_en_d;
            mem_wren    <= mem_wren_d;
            mem_addr    <= mem_addr_d;
            mem_byteena <= mem_byteena_d;
            mem_wdata   <= mem_wdata_d;
            if (take) begin
                ptr      <= ~sel_port;
                cur_port <= sel_port;
                cur_we   <= sel_we;
                cur_lane <= sel_lane;
            end
        end
    end

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Directed bench for byte_mem_arbiter with a small registered-read RAM model.
module tb_byte_mem_arbiter;

    localparam int AW = 10;

    logic            clk;
    logic            rst;
    logic [1:0]      req;
    logic [1:0]      we;
    logic [2*AW-1:0] addr;
    logic [3:0]      lane;
    logic [15:0]     wdata;
    logic [1:0]      gnt;
    logic [1:0]      done;
    logic            err;
    logic [7:0]      rdata;
    logic            mem_en;
    logic            mem_wren;
    logic [AW-1:0]   mem_addr;
    logic [2:0]      mem_byteena;
    logic [23:0]     mem_wdata;
    logic [23:0]     mem_rdata;
    logic [2:0]      state_dbg;

    int checks;
    int failures;

    logic [23:0] ram [0:1023];

    byte_mem_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .lane(lane),
        .wdata(wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_byteena(mem_byteena), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, byte-masked write; word 5 preloaded on reset
    always @(posedge clk) begin
        if (rst) begin
            ram[5] <= 24'h3C0011;
        end else if (mem_en) begin
            if (mem_wren)
                ram[mem_addr] <= (ram[mem_addr] & ~{{8{mem_byteena[2]}}, {8{mem_byteena[1]}}, {8{mem_byteena[0]}}})
                               | (mem_wdata & {{8{mem_byteena[2]}}, {8{mem_byteena[1]}}, {8{mem_byteena[0]}}});
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [1:0] l, input logic [7:0] d);
        if (p == 0) begin
            we[0] = w; addr[AW-1:0] = a; lane[1:0] = l; wdata[7:0] = d;
        end else begin
            we[1] = w; addr[2*AW-1:AW] = a; lane[3:2] = l; wdata[15:8] = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_rdata"}, 32'(rdata), 32'h0);
        check({tag, "_mem_en"}, 32'(mem_en), 32'h0);
        check({tag, "_mem_wren"}, 32'(mem_wren), 32'h0);
        check({tag, "_mem_byteena"}, 32'(mem_byteena), 32'h0);
        check({tag, "_state"}, 32'(state_dbg), 32'h0);
    endtask

    initial begin
        int n;
        int k;
        int d_cyc [2];
        logic [1:0] exp_g;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        req = 2'b00;
        we = 2'b00;
        addr = '0;
        lane = 4'h0;
        wdata = 16'h0000;
        tick();
        do_reset();
        tick();

        // reset state
        check_idle_outputs("reset");
        check("reset_mem_addr", 32'(mem_addr), 32'h0);
        check("reset_mem_wdata", 32'(mem_wdata), 32'h0);

        // port 0 write, addr 5, lane 1, A5
        set_port(0, 1'b1, 10'd5, 2'd1, 8'hA5);
        req = 2'b01;
        tick();
        check("wr_gnt", 32'(gnt), 32'h1);
        check("wr_mem_en", 32'(mem_en), 32'h1);
        check("wr_mem_wren", 32'(mem_wren), 32'h1);
        check("wr_mem_addr", 32'(mem_addr), 32'h5);
        check("wr_byteena", 32'(mem_byteena), 32'h2);
        check("wr_wdata", 32'(mem_wdata), 32'h00A500);
        check("wr_done_early", 32'(done), 32'h0);
        req = 2'b00;
        tick();
        check("wr_done", 32'(done), 32'h1);
        check("wr_err", 32'(err), 32'h0);
        check("wr_en_off", 32'(mem_en), 32'h0);
        check("wr_wdata_hold", 32'(mem_wdata), 32'h00A500);
        tick();
        check_idle_outputs("wr_after");

        // port 1 read, addr 5, lane 2 (word now 3C_A5_11)
        set_port(1, 1'b0, 10'd5, 2'd2, 8'h00);
        req = 2'b10;
        tick();
        check("rd1_gnt", 32'(gnt), 32'h2);
        check("rd1_mem_en", 32'(mem_en), 32'h1);
        check("rd1_wren", 32'(mem_wren), 32'h0);
        check("rd1_byteena", 32'(mem_byteena), 32'h4);
        req = 2'b00;
        tick();
        check("rd1_wait_en", 32'(mem_en), 32'h0);
        check("rd1_wait_done", 32'(done), 32'h0);
        tick();
        check("rd1_cap_done", 32'(done), 32'h0);
        check("rd1_cap_rdata", 32'(rdata), 32'h0);
        tick();
        check("rd1_done", 32'(done), 32'h2);
        check("rd1_rdata", 32'(rdata), 32'h3C);
        check("rd1_err", 32'(err), 32'h0);
        check("rd1_wren_resp", 32'(mem_wren), 32'h0);
        tick();
        check_idle_outputs("rd1_after");

        // port 0 read lane 0 and lane 1 of the same word
        set_port(0, 1'b0, 10'd5, 2'd0, 8'h00);
        req = 2'b01;
        tick();
        req = 2'b00;
        tick(); tick(); tick();
        check("rd0_done", 32'(done), 32'h1);
        check("rd0_rdata", 32'(rdata), 32'h11);
        tick();
        set_port(0, 1'b0, 10'd5, 2'd1, 8'h00);
        req = 2'b01;
        tick();
        req = 2'b00;
        tick(); tick(); tick();
        check("rd0l1_rdata", 32'(rdata), 32'hA5);
        tick();

        // both ports request continuously from reset: 0,1,0,1
        do_reset();
        set_port(0, 1'b1, 10'd10, 2'd0, 8'h11);
        set_port(1, 1'b1, 10'd20, 2'd2, 8'h22);
        req = 2'b11;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            tick();
            if (gnt != 2'b00) begin
                exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
                check("rr_gnt", 32'(gnt), 32'(exp_g));
                check("rr_wdata", 32'(mem_wdata), (n % 2 == 0) ? 32'h000011 : 32'h220000);
                check("rr_addr", 32'(mem_addr), (n % 2 == 0) ? 32'd10 : 32'd20);
                n++;
            end
        end
        check("rr_grant_count", 32'(n), 32'd4);
        req = 2'b00;
        tick(); tick();

        // invalid lane: error response, no RAM strobe
        set_port(0, 1'b1, 10'd3, 2'd3, 8'hFF);
        req = 2'b01;
        tick();
        check("bad_gnt", 32'(gnt), 32'h1);
        check("bad_mem_en_issue", 32'(mem_en), 32'h0);
        check("bad_byteena", 32'(mem_byteena), 32'h0);
        req = 2'b00;
        tick();
        check("bad_done", 32'(done), 32'h1);
        check("bad_err", 32'(err), 32'h1);
        check("bad_mem_en_resp", 32'(mem_en), 32'h0);
        check("bad_addr_hold", 32'(mem_addr), 32'd20);
        tick();
        check("bad_err_clear", 32'(err), 32'h0);

        // reset during WAIT of a port 0 read
        set_port(0, 1'b0, 10'd5, 2'd0, 8'h00);
        req = 2'b01;
        tick();
        check("rstw_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        tick();
        check("rstw_in_wait", 32'(state_dbg), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("rstw");
        check("rstw_mem_addr", 32'(mem_addr), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rstw_no_done", 32'(done), 32'h0);
        end
        set_port(1, 1'b0, 10'd5, 2'd2, 8'h00);
        req = 2'b10;
        tick();
        check("rstw_p1_gnt", 32'(gnt), 32'h2);
        req = 2'b00;
        tick(); tick(); tick();
        check("rstw_p1_done", 32'(done), 32'h2);
        check("rstw_p1_rdata", 32'(rdata), 32'h3C);
        tick();

        // back-to-back port 0 writes with req held high
        set_port(0, 1'b1, 10'd7, 2'd0, 8'h5A);
        req = 2'b01;
        n = 0;
        k = 0;
        d_cyc[0] = 0;
        d_cyc[1] = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (gnt == 2'b01) begin
                if (n == 0) begin
                    check("b2b_wdata0", 32'(mem_wdata), 32'h00005A);
                    check("b2b_be0", 32'(mem_byteena), 32'h1);
                    set_port(0, 1'b1, 10'd8, 2'd2, 8'hC3);
                end else if (n == 1) begin
                    check("b2b_wdata1", 32'(mem_wdata), 32'hC30000);
                    check("b2b_be1", 32'(mem_byteena), 32'h4);
                    check("b2b_addr1", 32'(mem_addr), 32'd8);
                    req = 2'b00;
                end
                n++;
            end
            if (done == 2'b01 && k < 2) begin
                d_cyc[k] = c;
                k++;
            end
        end
        check("b2b_grants", 32'(n), 32'd2);
        check("b2b_dones", 32'(k), 32'd2);
        check("b2b_gap", 32'(d_cyc[1] - d_cyc[0]), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
